// File: rtl/flex_down_timer.sv
// Programmable down-counting timer: a prescaled tick counts a loaded interval down to
// zero, then either stops in EXPIRED (one-shot) or reloads and keeps running (periodic).
module flex_down_timer #(
    parameter int NUM_CNT_BITS  = 8,
    parameter int PRESCALE_BITS = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [NUM_CNT_BITS-1:0]  load_val,
    input  logic [PRESCALE_BITS-1:0] prescale,
    input  logic                     periodic,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     pause,
    output logic [NUM_CNT_BITS-1:0]  count_out,
    output logic                     busy,
    output logic                     done,
    output logic                     expired
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [NUM_CNT_BITS-1:0]  r_count;
    logic [NUM_CNT_BITS-1:0]  r_reload;
    logic [PRESCALE_BITS-1:0] r_prescale;
    logic [PRESCALE_BITS-1:0] r_pcnt;
    logic                     r_periodic;
    logic                     r_done;

    logic w_start_ok;
    logic w_active;
    logic w_tick;
    logic w_expire;

    assign w_start_ok = start && (load_val != '0);
    // A PAUSED cycle with pause released counts immediately, so each pause cycle
    // costs exactly one cycle of delay.
    assign w_active   = ((r_state == RUN) || (r_state == PAUSED)) && !pause;
    assign w_tick     = (r_pcnt == r_prescale);
    assign w_expire   = w_active && w_tick && (r_count == NUM_CNT_BITS'(1));

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of block ordering.
            r_state <= w_next_state;
        end
    end

    // Next-state logic; priority is stop > start > pause
    always_comb begin
        // NOTE: default first so no path leaves w_next_state unassigned (no latch).
        w_next_state = r_state;
        if (stop) begin
            w_next_state = IDLE;
        end else if (w_start_ok) begin
            w_next_state = RUN;
        end else begin
            case (r_state)
                RUN, PAUSED: begin
                    if (pause)                       w_next_state = PAUSED;
                    else if (w_expire && !r_periodic) w_next_state = EXPIRED;
                    else                             w_next_state = RUN;
                end
                default: w_next_state = r_state;
            endcase
        end
    end

    // Counter, prescaler, latched configuration and the registered done pulse
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_count    <= '0;
            r_reload   <= '0;
            r_prescale <= '0;
            r_pcnt     <= '0;
            r_periodic <= 1'b0;
            r_done     <= 1'b0;
        end else if (stop) begin
            r_count <= '0;
            r_pcnt  <= '0;
            r_done  <= 1'b0;
        end else if (w_start_ok) begin
            // A restart abandons the running interval without reporting its expiry.
            r_reload   <= load_val;
            r_prescale <= prescale;
            r_periodic <= periodic;
            r_count    <= load_val;
            r_pcnt     <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_active) begin
                r_pcnt <= w_tick ? '0 : r_pcnt + PRESCALE_BITS'(1);
                if (w_tick) begin
                    if (r_count > NUM_CNT_BITS'(1)) begin
                        r_count <= r_count - NUM_CNT_BITS'(1);
                    end else if (r_count == NUM_CNT_BITS'(1)) begin
                        r_count <= r_periodic ? r_reload : '0;
                        r_done  <= 1'b1;
                    end
                end
            end
        end
    end

    // Output logic
    always_comb begin
        busy    = (r_state == RUN) || (r_state == PAUSED);
        expired = (r_state == EXPIRED);
    end

    assign count_out = r_count;
    assign done      = r_done;

endmodule
